// File: rtl/morse_stream_decoder.sv
// Morse key receiver: times a synchronised key signal, classifies dots/dashes,
// decodes A-Z/0-9 plus word space and ETX, and buffers characters in a small FIFO.
module morse_stream_decoder #(
    parameter int UNIT_CYCLES = 4,
    parameter int IDLE_UNITS  = 20,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       key_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       err_sym,
    output logic       overflow,
    input  logic       clr_ovf,
    output logic       busy
);
    localparam int CNT_W = $clog2(IDLE_UNITS*UNIT_CYCLES+1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_U  = CNT_W'(UNIT_CYCLES/2);
    localparam logic [CNT_W-1:0] M_MAX   = CNT_W'(2*UNIT_CYCLES);
    localparam logic [CNT_W-1:0] THR_LTR = CNT_W'(3*UNIT_CYCLES);
    localparam logic [CNT_W-1:0] THR_WRD = CNT_W'(7*UNIT_CYCLES);
    localparam logic [CNT_W-1:0] L_MAX   = CNT_W'(IDLE_UNITS*UNIT_CYCLES);
    localparam logic [PTR_W:0]   FULL_C  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_GAP} state_t;

    // Code layout {len[2:0], pat[4:0]}: first element in pat[len-1], dash = 1.
    function automatic logic [7:0] decode_code(input logic [7:0] code);
        logic [7:0] ch;
        ch = 8'h00;
        case (code)
            {3'd1, 5'b00000}: ch = "E";  {3'd1, 5'b00001}: ch = "T";
            {3'd2, 5'b00000}: ch = "I";  {3'd2, 5'b00001}: ch = "A";
            {3'd2, 5'b00010}: ch = "N";  {3'd2, 5'b00011}: ch = "M";
            {3'd3, 5'b00000}: ch = "S";  {3'd3, 5'b00001}: ch = "U";
            {3'd3, 5'b00010}: ch = "R";  {3'd3, 5'b00011}: ch = "W";
            {3'd3, 5'b00100}: ch = "D";  {3'd3, 5'b00101}: ch = "K";
            {3'd3, 5'b00110}: ch = "G";  {3'd3, 5'b00111}: ch = "O";
            {3'd4, 5'b00000}: ch = "H";  {3'd4, 5'b00001}: ch = "V";
            {3'd4, 5'b00010}: ch = "F";  {3'd4, 5'b00100}: ch = "L";
            {3'd4, 5'b00110}: ch = "P";  {3'd4, 5'b00111}: ch = "J";
            {3'd4, 5'b01000}: ch = "B";  {3'd4, 5'b01001}: ch = "X";
            {3'd4, 5'b01010}: ch = "C";  {3'd4, 5'b01011}: ch = "Y";
            {3'd4, 5'b01100}: ch = "Z";  {3'd4, 5'b01101}: ch = "Q";
            {3'd5, 5'b11111}: ch = "0";  {3'd5, 5'b01111}: ch = "1";
            {3'd5, 5'b00111}: ch = "2";  {3'd5, 5'b00011}: ch = "3";
            {3'd5, 5'b00001}: ch = "4";  {3'd5, 5'b00000}: ch = "5";
            {3'd5, 5'b10000}: ch = "6";  {3'd5, 5'b11000}: ch = "7";
            {3'd5, 5'b11100}: ch = "8";  {3'd5, 5'b11110}: ch = "9";
            default:          ch = 8'h00;
        endcase
        return ch;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       m_q, m_d, l_q, l_d;
    state_t                 state_q, state_d;
    logic [2:0]             len_q, len_d;
    logic [4:0]             pat_q, pat_d;
    logic                   ovl_q, ovl_d, wpend_q, wpend_d, epend_q, epend_d;
    logic                   err_q, err_d, ovf_q, ovf_d;
    logic [PTR_W-1:0]       rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W:0]         cnt_q, cnt_d;
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic                   k, push, pop, wr_en;
    logic [7:0]             push_data, dec;

    assign k          = sync_q[SYNC_STAGES-1];
    assign data_valid = (cnt_q != '0);
    assign data_out   = data_valid ? mem_q[rd_q] : 8'h00;
    assign err_sym    = err_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != S_IDLE);

    // l_d is the gap length including the current cycle; gap events key off it.
    always_comb begin
        m_d = k ? ((m_q == M_MAX) ? M_MAX : m_q + CNT_W'(1)) : '0;
        l_d = k ? '0 : ((l_q == L_MAX) ? L_MAX : l_q + CNT_W'(1));
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        pat_d     = pat_q;
        ovl_d     = ovl_q;
        wpend_d   = wpend_q;
        epend_d   = epend_q;
        err_d     = 1'b0;
        push      = 1'b0;
        push_data = 8'h00;
        dec       = decode_code({len_q, pat_q});
        if (!en) begin
            state_d = S_IDLE;
            len_d   = '0;
            pat_d   = '0;
            ovl_d   = 1'b0;
            wpend_d = 1'b0;
            epend_d = 1'b0;
        end else begin
            case (state_q)
                // Only a fresh rising edge starts a mark, so a mark already in
                // progress when the decoder is enabled is ignored.
                S_IDLE: if (k && m_q == '0) state_d = S_MARK;
                S_MARK: if (!k) begin
                    state_d = S_GAP;
                    if (m_q >= HALF_U) begin
                        if (len_q == 3'd5) begin
                            ovl_d = 1'b1;
                        end else begin
                            pat_d = {pat_q[3:0], (m_q >= M_MAX)};
                            len_d = len_q + 3'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (k) begin
                        state_d = S_MARK;
                    end else if (l_d == THR_LTR && len_q != 3'd0) begin
                        if (!ovl_q && dec != 8'h00) begin
                            push      = 1'b1;
                            push_data = dec;
                            wpend_d   = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        len_d = '0;
                        pat_d = '0;
                        ovl_d = 1'b0;
                    end else if (l_d == THR_WRD && wpend_q) begin
                        push      = 1'b1;
                        push_data = 8'h20;
                        wpend_d   = 1'b0;
                        epend_d   = 1'b1;
                    end else if (l_d == L_MAX && epend_q) begin
                        push      = 1'b1;
                        push_data = 8'h03;
                        epend_d   = 1'b0;
                        state_d   = S_IDLE;
                    end else if (len_q == 3'd0 && !wpend_q && !epend_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same cycle.
    always_comb begin
        pop   = data_valid && data_ready;
        wr_en = push && ((cnt_q != FULL_C) || pop);
        ovf_d = clr_ovf ? 1'b0 : (ovf_q || (push && !wr_en));
        rd_d  = pop ? rd_q + PTR_W'(1) : rd_q;
        wr_d  = wr_en ? wr_q + PTR_W'(1) : wr_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            m_q     <= '0;
            l_q     <= '0;
            state_q <= S_IDLE;
            len_q   <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            wpend_q <= 1'b0;
            epend_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], key_in};
            m_q     <= m_d;
            l_q     <= l_d;
            state_q <= state_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            wpend_q <= wpend_d;
            epend_q <= epend_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= push_data;
    end

endmodule
